// File: rtl/apb_reg_bridge.sv
// APB3 slave that turns each APB transfer into a single reg-bus request.
// Adds a misalignment check, a response timeout and a saturating error counter.
module apb_reg_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADC_AB1E
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                    reg_write_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [3:0]              reg_wstrb_o,
    output logic                    reg_valid_o,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_error_i,
    input  logic                    reg_ready_i,
    output logic [7:0]              err_count_o
);

    // Counter only has to reach TIMEOUT_CYCLES-1: the transition out of REQ happens on that cycle.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_reg_valid;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic [CNT_W-1:0]        r_tcnt;
    logic [7:0]              r_err_cnt;
    logic [DATA_WIDTH-1:0]   w_resp_data;
    logic                    w_resp_err;
    logic                    w_to_hit;

    assign w_to_hit = (TIMEOUT_CYCLES != 32'd0) && (r_tcnt == TO_LAST);

    // Next-state decode and response capture values.
    always_comb begin
        w_state_nxt = r_state;
        w_resp_data = '0;
        w_resp_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psel_i) begin
                    if (paddr_i[1:0] != 2'b00) begin
                        w_state_nxt = S_RESP;
                        w_resp_data = ERR_RDATA;
                        w_resp_err  = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                // A ready arriving on the timeout cycle still yields a normal response.
                if (reg_ready_i) begin
                    w_state_nxt = S_RESP;
                    w_resp_err  = reg_error_i;
                    if (reg_error_i) begin
                        w_resp_data = ERR_RDATA;
                    end else if (r_write) begin
                        w_resp_data = '0;
                    end else begin
                        w_resp_data = reg_rdata_i;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt = S_RESP;
                    w_resp_data = ERR_RDATA;
                    w_resp_err  = 1'b1;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_RESP: begin
                if (!psel_i) begin
                    w_state_nxt = S_IDLE;
                end else if (penable_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, request latches, registered outputs and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= 4'h0;
            r_reg_valid <= 1'b0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_prdata    <= '0;
            r_tcnt      <= '0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_reg_valid <= (w_state_nxt == S_REQ);
            r_pready    <= (w_state_nxt == S_RESP);

            if ((r_state == S_IDLE) && psel_i) begin
                r_addr  <= paddr_i;
                r_write <= pwrite_i;
                r_wdata <= pwdata_i;
                r_wstrb <= pwrite_i ? 4'hF : 4'h0;
            end

            // Response values are captured on entry to RESP and held until it is left.
            if (w_state_nxt == S_RESP) begin
                if (r_state != S_RESP) begin
                    r_prdata  <= w_resp_data;
                    r_pslverr <= w_resp_err;
                end
            end else begin
                r_prdata  <= '0;
                r_pslverr <= 1'b0;
            end

            if ((r_state == S_REQ) && (w_state_nxt == S_REQ)) begin
                r_tcnt <= r_tcnt + CNT_W'(1);
            end else begin
                r_tcnt <= '0;
            end

            if ((r_state == S_RESP) && psel_i && penable_i && r_pslverr && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign prdata_o    = r_prdata;
    assign pready_o    = r_pready;
    assign pslverr_o   = r_pslverr;
    assign reg_addr_o  = r_addr;
    assign reg_write_o = r_write;
    assign reg_wdata_o = r_wdata;
    assign reg_wstrb_o = r_wstrb;
    assign reg_valid_o = r_reg_valid;
    assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge: one instance with the default timeout,
// one with TIMEOUT_CYCLES=4 and the reg-bus never answering.
module tb_apb_reg_bridge;

    localparam logic [31:0] ERR = 32'hBADC_AB1E;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'd0, pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] reg_addr, reg_wdata;
    logic        reg_write, reg_valid;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata = 32'd0;
    logic        reg_error = 1'b0, reg_ready = 1'b0;
    logic [7:0]  err_count;

    logic        psel_t = 1'b0, penable_t = 1'b0;
    logic        rdy_t = 1'b0;
    logic [31:0] prdata_t, reg_addr_t, reg_wdata_t;
    logic        pready_t, pslverr_t, reg_write_t, reg_valid_t;
    logic [3:0]  reg_wstrb_t;
    logic [7:0]  err_count_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_reg_bridge u_dut (
        .clk_i(clk), .rst_i(rst),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(reg_ready),
        .err_count_o(err_count)
    );

    apb_reg_bridge #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk_i(clk), .rst_i(rst),
        .psel_i(psel_t), .penable_i(penable_t), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata_t), .pready_o(pready_t), .pslverr_o(pslverr_t),
        .reg_addr_o(reg_addr_t), .reg_write_o(reg_write_t), .reg_wdata_o(reg_wdata_t),
        .reg_wstrb_o(reg_wstrb_t), .reg_valid_o(reg_valid_t),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(rdy_t),
        .err_count_o(err_count_t)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer on u_dut; reg_ready is held low for rdy_delay REQ cycles.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_delay, input logic [31:0] rdata, input logic err,
                        output logic [31:0] o_prdata, output logic o_slverr,
                        output int o_cycles, output int o_valid, output logic o_stable);
        int cyc;
        int vld;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        reg_ready = 1'b0; reg_rdata = rdata; reg_error = err;
        cyc = 1; vld = 0; o_stable = 1'b1;
        tick;
        penable = 1'b1;
        while ((pready !== 1'b1) && (cyc < 64)) begin
            if (reg_valid === 1'b1) begin
                vld++;
                if ((reg_addr !== addr) || (reg_write !== wr) || (reg_wdata !== wdata) ||
                    (reg_wstrb !== (wr ? 4'hF : 4'h0)))
                    o_stable = 1'b0;
            end
            reg_ready = (vld > rdy_delay);
            cyc++;
            tick;
        end
        o_prdata = prdata;
        o_slverr = pslverr;
        o_cycles = cyc + 1;
        o_valid  = vld;
        tick;
        psel = 1'b0; penable = 1'b0; reg_ready = 1'b0; reg_error = 1'b0;
    endtask

    logic [31:0] rd;
    logic        se, st;
    int          cy, vl;
    int          to_bad;
    int          tv, tc;

    initial begin
        repeat (2) tick;
        chk("rst_pready",   32'(pready), 32'd0);
        chk("rst_pslverr",  32'(pslverr), 32'd0);
        chk("rst_valid",    32'(reg_valid), 32'd0);
        chk("rst_prdata",   prdata, 32'd0);
        chk("rst_errcnt",   32'(err_count), 32'd0);
        chk("rst_addr",     reg_addr, 32'd0);
        chk("rst_wstrb",    32'(reg_wstrb), 32'd0);
        chk("rst_write",    32'(reg_write), 32'd0);
        chk("rst_to_valid", 32'(reg_valid_t), 32'd0);
        rst = 1'b0;
        tick;

        // Write with immediate ready
        xfer(1'b1, 32'h0000_0000, 32'h1234_5678, 0, 32'h0, 1'b0, rd, se, cy, vl, st);
        chk("wr_cycles", 32'(cy), 32'd3);
        chk("wr_valid",  32'(vl), 32'd1);
        chk("wr_stable", 32'(st), 32'd1);
        chk("wr_slverr", 32'(se), 32'd0);
        chk("wr_prdata", rd, 32'd0);
        chk("wr_pready_after", 32'(pready), 32'd0);

        // Read with five wait cycles
        xfer(1'b0, 32'h0000_0008, 32'h0, 5, 32'h0000_0003, 1'b0, rd, se, cy, vl, st);
        chk("rdw_cycles", 32'(cy), 32'd8);
        chk("rdw_valid",  32'(vl), 32'd6);
        chk("rdw_stable", 32'(st), 32'd1);
        chk("rdw_prdata", rd, 32'h0000_0003);
        chk("rdw_slverr", 32'(se), 32'd0);

        // Misaligned read
        xfer(1'b0, 32'h0000_0002, 32'h0, 0, 32'h5555_5555, 1'b0, rd, se, cy, vl, st);
        chk("mis_valid",  32'(vl), 32'd0);
        chk("mis_cycles", 32'(cy), 32'd2);
        chk("mis_slverr", 32'(se), 32'd1);
        chk("mis_prdata", rd, ERR);
        chk("mis_errcnt", 32'(err_count), 32'd1);

        // Reg error followed back-to-back by a clean read
        xfer(1'b0, 32'h0000_0004, 32'h0, 0, 32'h1111_1111, 1'b1, rd, se, cy, vl, st);
        chk("rerr_slverr", 32'(se), 32'd1);
        chk("rerr_prdata", rd, ERR);
        chk("rerr_errcnt", 32'(err_count), 32'd2);
        xfer(1'b0, 32'h0000_0000, 32'h0, 0, 32'hA5A5_A5A5, 1'b0, rd, se, cy, vl, st);
        chk("b2b_slverr", 32'(se), 32'd0);
        chk("b2b_prdata", rd, 32'hA5A5_A5A5);
        chk("b2b_cycles", 32'(cy), 32'd3);
        chk("b2b_errcnt", 32'(err_count), 32'd2);

        // Write with reg error
        xfer(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 1, 32'h0, 1'b1, rd, se, cy, vl, st);
        chk("werr_slverr", 32'(se), 32'd1);
        chk("werr_prdata", rd, ERR);
        chk("werr_cycles", 32'(cy), 32'd4);
        chk("werr_errcnt", 32'(err_count), 32'd3);

        // Master abort during an error response does not count
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0006;
        tick;
        chk("abort_pready", 32'(pready), 32'd1);
        psel = 1'b0;
        tick;
        chk("abort_idle",   32'(pready), 32'd0);
        chk("abort_errcnt", 32'(err_count), 32'd3);

        // Reset in the middle of REQ
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0010; reg_ready = 1'b0;
        tick;
        chk("rstreq_valid_before", 32'(reg_valid), 32'd1);
        rst = 1'b1; penable = 1'b1;
        tick;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("rstreq_valid",  32'(reg_valid), 32'd0);
        chk("rstreq_pready", 32'(pready), 32'd0);
        chk("rstreq_errcnt", 32'(err_count), 32'd0);
        tick;
        chk("rstreq_idle_valid", 32'(reg_valid), 32'd0);
        xfer(1'b0, 32'h0000_0010, 32'h0, 2, 32'hCAFE_0010, 1'b0, rd, se, cy, vl, st);
        chk("post_rst_prdata", rd, 32'hCAFE_0010);
        chk("post_rst_slverr", 32'(se), 32'd0);
        chk("post_rst_cycles", 32'(cy), 32'd5);
        chk("post_rst_valid",  32'(vl), 32'd3);

        // Timeout instance: reg-bus never answers
        to_bad = 0;
        pwrite = 1'b0; paddr = 32'h0000_0020;
        for (int i = 0; i < 300; i++) begin
            psel_t = 1'b1; penable_t = 1'b0;
            tick;
            penable_t = 1'b1;
            tv = 0; tc = 0;
            if (i == 0) begin
                chk("to_addr",  reg_addr_t, 32'h0000_0020);
                chk("to_write", 32'(reg_write_t), 32'd0);
                chk("to_wstrb", 32'(reg_wstrb_t), 32'd0);
                chk("to_wdata", reg_wdata_t, 32'd0);
            end
            while ((pready_t !== 1'b1) && (tc < 20)) begin
                if (reg_valid_t === 1'b1) tv++;
                tc++;
                tick;
            end
            if (i == 0) begin
                chk("to_valid_cycles", 32'(tv), 32'd4);
                chk("to_slverr", 32'(pslverr_t), 32'd1);
                chk("to_prdata", prdata_t, ERR);
                chk("to_errcnt_pre", 32'(err_count_t), 32'd0);
            end
            if ((tv != 4) || (pslverr_t !== 1'b1) || (prdata_t !== ERR) || (tc >= 20))
                to_bad++;
            tick;
            psel_t = 1'b0; penable_t = 1'b0;
            if (i == 0)   chk("to_errcnt_1",   32'(err_count_t), 32'd1);
            if (i == 253) chk("to_errcnt_254", 32'(err_count_t), 32'd254);
        end
        chk("to_all_iters",  32'(to_bad), 32'd0);
        chk("to_errcnt_sat", 32'(err_count_t), 32'h0000_00FF);
        chk("to_pready_idle", 32'(pready_t), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
